// File: rtl/theta_column_parity_func.sv
// Keccak theta over a 5x5x64 state streamed one 25-bit slice per line.
// All 64 slices and their column parities are buffered during LOAD; EMIT
// then replays each slice XORed with C[x-1][z] and C[x+1][z-1].
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capturing slices z = 0..63 on in_valid
// EMIT  | registering one theta slice per cycle, z = 0..63
// DONE  | last slice on the output; donee is raised on the next cycle
module theta_column_parity_func #(
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 6,
    parameter int LINE_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] line_in,
    output logic              write_enable,
    output logic [LINE_W-1:0] write_value,
    output logic [CNT_W-1:0]  cnt_value,
    output logic              donee
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [LINE_W-1:0]   mem_q [DEPTH];
    logic [LINE_W-1:0]   mem_d [DEPTH];
    logic [4:0]          par_q [DEPTH];
    logic [4:0]          par_d [DEPTH];
    logic                write_enable_q, write_enable_d;
    logic [LINE_W-1:0]   write_value_q, write_value_d;
    logic [CNT_W-1:0]    cnt_value_q, cnt_value_d;
    logic                donee_q, donee_d;

    logic [CNT_W-1:0]    z_prev;
    logic [4:0]          par_cur;
    logic [4:0]          par_prev;
    logic [LINE_W-1:0]   theta_slice;

    // Column parity of one slice: bit x is the XOR of the five rows y.
    function automatic logic [4:0] col_par(input logic [LINE_W-1:0] s);
        logic [4:0] p;
        for (int x = 0; x < 5; x++) begin
            p[x] = s[x] ^ s[5+x] ^ s[10+x] ^ s[15+x] ^ s[20+x];
        end
        return p;
    endfunction

    // Theta of the slice at out_cnt; z-1 wraps naturally in the counter width.
    always_comb begin
        z_prev      = out_cnt_q - CNT_W'(1);
        par_cur     = par_q[out_cnt_q];
        par_prev    = par_q[z_prev];
        theta_slice = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                theta_slice[5*y+x] = mem_q[out_cnt_q][5*y+x]
                                   ^ par_cur[(x+4)%5]
                                   ^ par_prev[(x+1)%5];
            end
        end
    end

    // Next-state, buffer writes and registered outputs.
    always_comb begin
        state_d        = state_q;
        in_cnt_d       = in_cnt_q;
        out_cnt_d      = out_cnt_q;
        mem_d          = mem_q;
        par_d          = par_q;
        write_enable_d = 1'b0;
        write_value_d  = write_value_q;
        cnt_value_d    = cnt_value_q;
        donee_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    mem_d[in_cnt_q] = line_in;
                    par_d[in_cnt_q] = col_par(line_in);
                    in_cnt_d        = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == CNT_W'(DEPTH-1)) state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                write_enable_d = 1'b1;
                write_value_d  = theta_slice;
                cnt_value_d    = out_cnt_q;
                out_cnt_d      = out_cnt_q + CNT_W'(1);
                if (out_cnt_q == CNT_W'(DEPTH-1)) state_d = S_DONE;
            end
            S_DONE: begin
                donee_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            write_enable_q <= 1'b0;
            write_value_q  <= '0;
            cnt_value_q    <= '0;
            donee_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            write_enable_q <= write_enable_d;
            write_value_q  <= write_value_d;
            cnt_value_q    <= cnt_value_d;
            donee_q        <= donee_d;
        end
    end

    // Slice and parity buffers carry no reset; they are fully rewritten by LOAD.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        par_q <= par_d;
    end

    assign in_ready     = (state_q == S_LOAD);
    assign write_enable = write_enable_q;
    assign write_value  = write_value_q;
    assign cnt_value    = cnt_value_q;
    assign donee        = donee_q;

endmodule
